// File: rtl/register_file.sv
// MIPS general-purpose register file: one write port from write-back, two decode
// read ports with write-first bypass, and a sequencer that streams every register out.
module register_file #(
    parameter int NB_DATA           = 32,
    parameter int N_REGISTERS       = 32,
    parameter int NB_ADDR_REGISTERS = $clog2(N_REGISTERS)
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic [NB_DATA-1:0]           i_reg_w_data,
    input  logic [NB_ADDR_REGISTERS-1:0] i_reg_num,
    input  logic                         i_reg_w_en,
    input  logic [NB_ADDR_REGISTERS-1:0] i_rs_addr,
    input  logic [NB_ADDR_REGISTERS-1:0] i_rt_addr,
    output logic [NB_DATA-1:0]           o_rs_data,
    output logic [NB_DATA-1:0]           o_rt_data,
    input  logic                         i_dump_start,
    input  logic                         i_dump_ready,
    output logic                         o_dump_valid,
    output logic [NB_DATA-1:0]           o_dump_data,
    output logic [NB_ADDR_REGISTERS-1:0] o_dump_addr,
    output logic                         o_dump_busy,
    output logic                         o_dump_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_DONE
    } state_t;

    localparam logic [NB_ADDR_REGISTERS-1:0] LAST_IDX = NB_ADDR_REGISTERS'(N_REGISTERS - 1);

    logic [NB_DATA-1:0]           r_regs [N_REGISTERS];
    state_t                       r_state;
    logic [NB_ADDR_REGISTERS-1:0] r_idx;
    logic                         w_rs_bypass;
    logic                         w_rt_bypass;

    // Register 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int i = 0; i < N_REGISTERS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_reg_w_en && (i_reg_num != '0)) begin
            r_regs[i_reg_num] <= i_reg_w_data;
        end
    end

    assign w_rs_bypass = i_reg_w_en && (i_reg_num == i_rs_addr);
    assign w_rt_bypass = i_reg_w_en && (i_reg_num == i_rt_addr);

    always_comb begin
        o_rs_data = r_regs[i_rs_addr];
        if (i_rs_addr == '0) begin
            o_rs_data = '0;
        end else if (w_rs_bypass) begin
            o_rs_data = i_reg_w_data;
        end
    end

    always_comb begin
        o_rt_data = r_regs[i_rt_addr];
        if (i_rt_addr == '0) begin
            o_rt_data = '0;
        end else if (w_rt_bypass) begin
            o_rt_data = i_reg_w_data;
        end
    end

    // Dump handshake: a word transfers on any rising edge where o_dump_valid and
    // i_dump_ready are both high; while valid waits for ready, data and addr hold.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            o_dump_valid <= 1'b0;
            o_dump_data  <= '0;
            o_dump_addr  <= '0;
            o_dump_busy  <= 1'b0;
            o_dump_done  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_dump_start) begin
                        r_state     <= ST_LOAD;
                        r_idx       <= '0;
                        o_dump_busy <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    // Stored value only: a write at this same edge is not seen.
                    o_dump_data  <= (r_idx == '0) ? '0 : r_regs[r_idx];
                    o_dump_addr  <= r_idx;
                    o_dump_valid <= 1'b1;
                    r_state      <= ST_SEND;
                end
                ST_SEND: begin
                    if (i_dump_ready) begin
                        o_dump_valid <= 1'b0;
                        if (r_idx == LAST_IDX) begin
                            r_state     <= ST_DONE;
                            o_dump_done <= 1'b1;
                        end else begin
                            r_idx   <= r_idx + 1'b1;
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_DONE: begin
                    o_dump_done <= 1'b0;
                    o_dump_busy <= 1'b0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Bench for register_file: directed reads/writes checked inline, dump words checked
// by a monitor against an expected queue filled when each dump is launched.
module tb_register_file;

    localparam int NB_DATA = 32;
    localparam int N_REGS  = 32;
    localparam int NB_ADDR = 5;
    localparam int W       = NB_ADDR + NB_DATA;

    logic               clk;
    logic               i_reset;
    logic [NB_DATA-1:0] i_reg_w_data;
    logic [NB_ADDR-1:0] i_reg_num;
    logic               i_reg_w_en;
    logic [NB_ADDR-1:0] i_rs_addr;
    logic [NB_ADDR-1:0] i_rt_addr;
    logic [NB_DATA-1:0] o_rs_data;
    logic [NB_DATA-1:0] o_rt_data;
    logic               i_dump_start;
    logic               i_dump_ready;
    logic               o_dump_valid;
    logic [NB_DATA-1:0] o_dump_data;
    logic [NB_ADDR-1:0] o_dump_addr;
    logic               o_dump_busy;
    logic               o_dump_done;

    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_fail   = 0;

    register_file #(
        .NB_DATA          (NB_DATA),
        .N_REGISTERS      (N_REGS),
        .NB_ADDR_REGISTERS(NB_ADDR)
    ) dut (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_reg_w_data(i_reg_w_data),
        .i_reg_num   (i_reg_num),
        .i_reg_w_en  (i_reg_w_en),
        .i_rs_addr   (i_rs_addr),
        .i_rt_addr   (i_rt_addr),
        .o_rs_data   (o_rs_data),
        .o_rt_data   (o_rt_data),
        .i_dump_start(i_dump_start),
        .i_dump_ready(i_dump_ready),
        .o_dump_valid(o_dump_valid),
        .o_dump_data (o_dump_data),
        .o_dump_addr (o_dump_addr),
        .o_dump_busy (o_dump_busy),
        .o_dump_done (o_dump_done)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [NB_DATA-1:0] pat(input int i);
        return NB_DATA'(i * 32'h11);
    endfunction

    function automatic logic [W-1:0] word(input int a, input logic [NB_DATA-1:0] d);
        return {NB_ADDR'(a), d};
    endfunction

    // Monitor: every accepted dump word is popped and compared.
    always @(negedge clk) begin
        if (i_reset && o_dump_valid && i_dump_ready) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL dump_unexpected: got addr %0d data %h, expected no transfer",
                         o_dump_addr, o_dump_data);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if ({o_dump_addr, o_dump_data} !== e) begin
                    n_fail++;
                    $display("FAIL dump_word: got addr %0d data %h expected addr %0d data %h",
                             o_dump_addr, o_dump_data, e[W-1:NB_DATA], e[NB_DATA-1:0]);
                end
            end
        end
    end

    // ---------------- driver tasks (resume at posedge+1) ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input int a, input logic [NB_DATA-1:0] d);
        i_reg_w_en   = 1'b1;
        i_reg_num    = NB_ADDR'(a);
        i_reg_w_data = d;
        next_cycle();
        i_reg_w_en   = 1'b0;
    endtask

    task automatic check_dump_idle(input string tag);
        check({tag, "_valid"}, 64'(o_dump_valid), 64'd0);
        check({tag, "_busy"},  64'(o_dump_busy),  64'd0);
        check({tag, "_done"},  64'(o_dump_done),  64'd0);
        check({tag, "_data"},  64'(o_dump_data),  64'd0);
        check({tag, "_addr"},  64'(o_dump_addr),  64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int first_valid;
        int done_cyc;
        int done_cnt;

        i_reset      = 1'b0;
        i_reg_w_data = '0;
        i_reg_num    = '0;
        i_reg_w_en   = 1'b0;
        i_rs_addr    = '0;
        i_rt_addr    = '0;
        i_dump_start = 1'b0;
        i_dump_ready = 1'b1;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_dump_idle("reset0");
        next_cycle();
        i_reset = 1'b1;

        // reset clears array
        write_reg(5, 32'hDEADBEEF);
        i_rs_addr = 5;
        #1 check("pre_reset_reg5", 64'(o_rs_data), 64'hDEADBEEF);
        i_reset = 1'b0;
        next_cycle();
        i_reset = 1'b1;
        @(negedge clk);
        check("reset_reg5", 64'(o_rs_data), 64'h0);
        check_dump_idle("reset1");
        next_cycle();

        // writes and register 0
        i_reg_w_en = 1'b1; i_reg_num = 0; i_reg_w_data = 32'h1234; i_rs_addr = 0;
        #1 check("reg0_no_bypass", 64'(o_rs_data), 64'h0);
        next_cycle();
        i_reg_w_en = 1'b0;
        write_reg(31, 32'hCAFEF00D);
        i_rs_addr = 0; i_rt_addr = 31;
        @(negedge clk);
        check("reg0_read", 64'(o_rs_data), 64'h0);
        check("reg31_read", 64'(o_rt_data), 64'hCAFEF00D);
        next_cycle();

        // bypass
        i_rs_addr = 7; i_rt_addr = 7; i_reg_num = 7; i_reg_w_data = 32'hA5A5A5A5;
        i_reg_w_en = 1'b0;
        #1 check("nobyp_rs", 64'(o_rs_data), 64'h0);
        check("nobyp_rt", 64'(o_rt_data), 64'h0);
        i_reg_w_en = 1'b1;
        #1 check("byp_rs", 64'(o_rs_data), 64'hA5A5A5A5);
        check("byp_rt", 64'(o_rt_data), 64'hA5A5A5A5);
        next_cycle();
        i_reg_w_en = 1'b0;
        #1 check("reg7_stored", 64'(o_rs_data), 64'hA5A5A5A5);

        // fill reg[i] = i*0x11
        for (int i = 1; i < N_REGS; i++) write_reg(i, pat(i));
        i_rs_addr = 17; i_rt_addr = 30;
        #1 check("fill_rs17", 64'(o_rs_data), 64'(pat(17)));
        check("fill_rt30", 64'(o_rt_data), 64'(pat(30)));

        // full dump, ready held high, extra starts while busy
        for (int i = 0; i < N_REGS; i++) exp_q.push_back(word(i, (i == 0) ? '0 : pat(i)));
        first_valid = 0; done_cyc = 0; done_cnt = 0;
        i_dump_ready = 1'b1;
        i_dump_start = 1'b1;
        for (int k = 1; k <= 70; k++) begin
            next_cycle();
            i_dump_start = (k == 5 || k == 30);
            @(negedge clk);
            check("full_valid_pattern", 64'(o_dump_valid), 64'((k % 2 == 0) && (k <= 64)));
            if (o_dump_valid && first_valid == 0) first_valid = k;
            if (o_dump_done) begin done_cnt++; done_cyc = k; end
        end
        check("full_first_valid", 64'(first_valid), 64'd2);
        check("full_done_cycle", 64'(done_cyc), 64'd65);
        check("full_done_count", 64'(done_cnt), 64'd1);
        check("full_queue_empty", 64'(exp_q.size()), 64'd0);
        check("full_busy_end", 64'(o_dump_busy), 64'd0);

        // backpressure on word 3, reg3 rewritten during the stall
        for (int i = 0; i < N_REGS; i++) exp_q.push_back(word(i, (i == 0) ? '0 : pat(i)));
        done_cyc = 0; done_cnt = 0;
        next_cycle();
        i_dump_start = 1'b1;
        for (int k = 1; k <= 74; k++) begin
            next_cycle();
            i_dump_start = 1'b0;
            i_dump_ready = !(k >= 8 && k <= 12);
            i_reg_w_en   = (k == 9);
            i_reg_num    = 3;
            i_reg_w_data = 32'hFFFF0000;
            @(negedge clk);
            if (k >= 8 && k <= 13) begin
                check("stall_valid", 64'(o_dump_valid), 64'd1);
                check("stall_addr", 64'(o_dump_addr), 64'd3);
                check("stall_data", 64'(o_dump_data), 64'h33);
            end
            if (o_dump_done) begin done_cnt++; done_cyc = k; end
        end
        i_dump_ready = 1'b1;
        i_reg_w_en = 1'b0;
        i_rs_addr = 3;
        #1 check("stall_reg3_written", 64'(o_rs_data), 64'hFFFF0000);
        check("stall_done_cycle", 64'(done_cyc), 64'd70);
        check("stall_done_count", 64'(done_cnt), 64'd1);
        check("stall_queue_empty", 64'(exp_q.size()), 64'd0);

        // reset during SEND of word 10
        for (int i = 0; i < 10; i++)
            exp_q.push_back(word(i, (i == 0) ? '0 : ((i == 3) ? 32'hFFFF0000 : pat(i))));
        done_cnt = 0;
        next_cycle();
        i_dump_start = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            next_cycle();
            i_dump_start = 1'b0;
            i_dump_ready = (k != 22);
            i_reset      = (k != 22);
            @(negedge clk);
            if (k == 22) begin
                check("abort_pre_addr", 64'(o_dump_addr), 64'd10);
                check("abort_pre_valid", 64'(o_dump_valid), 64'd1);
            end
            if (k == 23) begin
                check("abort_busy", 64'(o_dump_busy), 64'd0);
                check("abort_valid", 64'(o_dump_valid), 64'd0);
                i_rs_addr = 5;
                #1 check("abort_array_cleared", 64'(o_rs_data), 64'd0);
            end
            if (o_dump_done) done_cnt++;
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);
        check("abort_queue_empty", 64'(exp_q.size()), 64'd0);

        // restart after abort: array was cleared, so every word is zero
        for (int i = 0; i < N_REGS; i++) exp_q.push_back(word(i, '0));
        done_cyc = 0; done_cnt = 0; first_valid = 0;
        i_dump_ready = 1'b1;
        i_dump_start = 1'b1;
        for (int k = 1; k <= 68; k++) begin
            next_cycle();
            i_dump_start = 1'b0;
            @(negedge clk);
            if (k == 2) check("restart_addr0", 64'(o_dump_addr), 64'd0);
            if (o_dump_valid && first_valid == 0) first_valid = k;
            if (o_dump_done) begin done_cnt++; done_cyc = k; end
        end
        check("restart_first_valid", 64'(first_valid), 64'd2);
        check("restart_done_cycle", 64'(done_cyc), 64'd65);
        check("restart_queue_empty", 64'(exp_q.size()), 64'd0);

        // final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
